if_stage: RTL and testbench
===========================

# if_stage

Instruction fetch stage of the 5-stage pipelined core. Holds the program counter, issues single-outstanding requests to instruction memory, and delivers each fetched word with its PC into the IF/ID pipeline register. Decode, including immediate generation, consumes the IF/ID register. Honours hazard-unit stalls and EX-stage branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address, equals PC register
- imem_req_ready  input  1  memory accepts request this cycle
- imem_rsp_valid  input  1  instruction word valid; never in the same cycle as its request's acceptance; cannot be back-pressured
- imem_rsp_data  input  32  instruction word
- stall  input  1  decode cannot accept; IF/ID holds
- redirect_valid  input  1  taken branch/jump; flush and refetch
- redirect_pc  input  32  new PC
- if_id_valid  output  1  IF/ID holds a live instruction
- if_id_pc  output  32  PC of if_id_instr
- if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32
- if_id_instr  output  32  instruction word, NOP (32'h0000_0013) when not valid
- if_misalign  output  1  present only with IF_MISALIGN_CHECK_EN

## Operation
- Registers: pc, state {FETCH, WAIT, HOLD, KILL}, buf_instr/buf_pc (one-entry buffer), IF/ID register.
- FETCH: imem_req_valid=1, addr=pc. On req_ready → WAIT.
- WAIT: on rsp_valid: if IF/ID free (!stall or !if_id_valid), load IF/ID {1, pc, pc+4, data}, pc<=pc+4, → FETCH; else latch into buffer, → HOLD.
- HOLD: no request. When stall=0: move buffer into IF/ID, pc<=pc+4, → FETCH.
- KILL: no request; wait for the orphaned response, discard it, → FETCH.
- stall=1 with if_id_valid=1: IF/ID unchanged. stall=1 with if_id_valid=0 does not block a load (bubble is free).
- redirect_valid has priority over stall and over every state action: pc<=redirect_pc, if_id_valid<=0, if_id_instr<=NOP, buffer dropped. Next state: KILL if a request is outstanding (state WAIT, or FETCH with req_ready this cycle), else FETCH. A response arriving in the redirect cycle is discarded; in that case → FETCH, not KILL.
- PC arithmetic is 32-bit wrap; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP, imem_req_valid=1 in first cycle after reset release; if_misalign=0.
- imem_req_valid/addr are combinational from state and pc only (no input paths).
- Response in cycle N appears on IF/ID outputs from cycle N+1.
- Peak throughput one instruction per 2 cycles (request cycle, response cycle) with a ready memory.
- Redirect in cycle N: IF/ID invalid from N+1; request to redirect_pc no earlier than N+1 (N+1 if nothing outstanding).
- Reset mid-fetch: all state cleared immediately; a response arriving after reset release while in FETCH is ignored (memory is reset together with the core).

## Configuration
- IF_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets if_misalign (sticky until reset), pc is still loaded, and state → HOLD-free idle: no further requests issued until reset.
- Undefined: no if_misalign port; redirect_pc[1:0] are ignored and forced to 2'b00 when loaded into pc.

## Structure
- Shared package rv_pkg: NOP_INSTR constant, if_id_t struct {valid, pc, pc_plus4, instr}, fetch state enum.
- One sub-module if_id_reg: IF/ID register with load, hold (stall) and flush (NOP insert) controls; FSM and PC logic stay in if_stage.

## Test plan
- Reset, ready memory returning 32'h0000_0093 at 0: first request addr 0; IF/ID = {1, 0, 4, 32'h0000_0093} two cycles after reset release; next request addr 4.
- stall held 3 cycles during WAIT with IF/ID full: response buffered, IF/ID unchanged, no new request; on stall drop, buffered word reaches IF/ID next cycle.
- redirect to 32'h0000_0100 while in WAIT: IF/ID flushed to NOP/invalid, old response dropped, next request addr 32'h100.
- redirect and rsp_valid in the same cycle: response discarded, request to redirect_pc next cycle.
- imem_req_ready low for 4 cycles: req_valid and addr stable throughout; pc = 32'hFFFF_FFFC fetch yields if_id_pc_plus4 = 0.
- With IF_MISALIGN_CHECK_EN, redirect to 32'h0000_0102: if_misalign=1 next cycle, no further requests.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core types: IF/ID bundle, fetch FSM states and the NOP encoding.
// Optional build macro IF_MISALIGN_CHECK_EN uses the IDLE fetch state.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        HOLD,
        KILL,
        IDLE
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold.
// When neither loaded nor held, the entry drains to a NOP bubble.
module if_id_reg
    import rv_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   load,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.valid    <= 1'b0;
            q.pc       <= 32'h0;
            q.pc_plus4 <= 32'h0;
            q.instr    <= NOP_INSTR;
        end else if (load && !flush) begin
            q <= d;
        end else if (flush || !hold) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem requests, IF/ID feed.
// Build macro IF_MISALIGN_CHECK_EN adds sticky misaligned-redirect detection.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        if_misalign
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_instr, buf_pc;
    logic        buf_we, load, if_free, outstanding;
    if_id_t      d, q;

    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign if_free        = !stall || !q.valid;

    // A response landing in the redirect cycle retires the outstanding slot.
    assign outstanding = (state == FETCH && imem_req_ready)
                       || ((state == WAIT || state == KILL)
                           && !imem_rsp_valid);

`ifdef IF_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) if_misalign <= 1'b0;
        else if (misaligned) if_misalign <= 1'b1;
    end
`endif

    always_comb begin
        pc_nxt     = pc;
        state_nxt  = state;
        load       = 1'b0;
        buf_we     = 1'b0;
        d.valid    = 1'b1;
        d.pc       = pc;
        d.pc_plus4 = pc + 32'd4;
        d.instr    = imem_rsp_data;
        if (redirect_valid) begin
            state_nxt = outstanding ? KILL : FETCH;
`ifdef IF_MISALIGN_CHECK_EN
            pc_nxt = redirect_pc;
            if (misaligned || state == IDLE) state_nxt = IDLE;
`else
            pc_nxt = redirect_pc & ~32'h3;
`endif
        end else begin
            unique case (state)
                FETCH: if (imem_req_ready) state_nxt = WAIT;
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (if_free) begin
                            load      = 1'b1;
                            pc_nxt    = pc + 32'd4;
                            state_nxt = FETCH;
                        end else begin
                            buf_we    = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    d.pc       = buf_pc;
                    d.pc_plus4 = buf_pc + 32'd4;
                    d.instr    = buf_instr;
                    if (if_free) begin
                        load      = 1'b1;
                        pc_nxt    = buf_pc + 32'd4;
                        state_nxt = FETCH;
                    end
                end
                KILL: if (imem_rsp_valid) state_nxt = FETCH;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (buf_we) begin
                buf_instr <= imem_rsp_data;
                buf_pc    <= pc;
            end
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .load  (load),
        .hold  (stall),
        .d     (d),
        .q     (q)
    );

    assign if_id_valid    = q.valid;
    assign if_id_pc       = q.pc;
    assign if_id_pc_plus4 = q.pc_plus4;
    assign if_id_instr    = q.instr;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage: one row per clock cycle.
// Extra misalign sequence runs when IF_MISALIGN_CHECK_EN is defined.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0000_0093;
    localparam logic [31:0] I1  = 32'h0010_0113;
    localparam logic [31:0] I2  = 32'h0020_0193;
    localparam logic [31:0] I3  = 32'h0030_0213;
    localparam logic [31:0] I4  = 32'h0040_0293;
    localparam logic [31:0] I5  = 32'h0050_0313;
    localparam logic [31:0] I6  = 32'h0060_0393;
    localparam logic [31:0] JK  = 32'hDEAD_BEEF;
`ifdef IF_MISALIGN_CHECK_EN
    localparam logic [31:0] R3  = 32'h0000_0300;
`else
    localparam logic [31:0] R3  = 32'h0000_0303;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        v;
    logic [31:0] ipc, ipc4, ins;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid),
        .imem_req_addr  (req_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .stall          (stall),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc),
        .if_id_valid    (v),
        .if_id_pc       (ipc),
        .if_id_pc_plus4 (ipc4),
        .if_id_instr    (ins)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .if_misalign    (misalign)
`endif
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        st;
        logic        rf;
        logic [31:0] rpc;
        logic        erq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] epc4;
        logic [31:0] eins;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic st,
                       input logic rf, input logic [31:0] rpc,
                       input logic erq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] epc,
                       input logic [31:0] epc4, input logic [31:0] eins);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rd = rd; r.st = st;
        r.rf = rf; r.rpc = rpc; r.erq = erq; r.eaddr = eaddr;
        r.ev = ev; r.epc = epc; r.epc4 = epc4; r.eins = eins;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic st,
                         input logic rf, input logic [31:0] rpc);
        req_ready = rdy; rsp_valid = rv; rsp_data = rd;
        stall = st; redir = rf; redir_pc = rpc;
    endtask

    initial begin
        // cycle-by-cycle: rdy rv rd st rf rpc | rq addr v pc pc4 instr
        add(1, 0, 0,  0, 0, 0,     1, 0,   0, 0, 0, NOP);
        add(0, 1, I0, 0, 0, 0,     0, 0,   0, 0, 0, NOP);
        add(1, 0, 0,  0, 0, 0,     1, 4,   1, 0, 4, I0);
        add(0, 1, I1, 0, 0, 0,     0, 4,   0, 0, 0, NOP);
        add(1, 0, 0,  1, 0, 0,     1, 8,   1, 4, 8, I1);
        add(0, 1, I2, 1, 0, 0,     0, 8,   1, 4, 8, I1);
        add(0, 0, 0,  1, 0, 0,     0, 8,   1, 4, 8, I1);
        add(0, 0, 0,  1, 0, 0,     0, 8,   1, 4, 8, I1);
        add(0, 0, 0,  0, 0, 0,     0, 8,   1, 4, 8, I1);
        add(0, 0, 0,  1, 0, 0,     1, 12,  1, 8, 12, I2);
        add(1, 0, 0,  1, 0, 0,     1, 12,  1, 8, 12, I2);
        add(0, 0, 0,  1, 1, 'h100, 0, 12,  1, 8, 12, I2);
        add(0, 0, 0,  0, 0, 0,     0, 'h100, 0, 0, 0, NOP);
        add(0, 1, JK, 0, 0, 0,     0, 'h100, 0, 0, 0, NOP);
        add(1, 0, 0,  0, 0, 0,     1, 'h100, 0, 0, 0, NOP);
        add(0, 1, I3, 0, 1, 'h200, 0, 'h100, 0, 0, 0, NOP);
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 0, 0, 0,  1, 'h200, 0, 0, 0, NOP);
        add(1, 0, 0,  0, 0, 0,     1, 'h200, 0, 0, 0, NOP);
        add(0, 1, I4, 0, 0, 0,     0, 'h200, 0, 0, 0, NOP);
        add(0, 0, 0,  0, 0, 0,     1, 'h204, 1, 'h200, 'h204, I4);
        add(0, 0, 0,  0, 1, 32'hFFFF_FFFC,
                                   1, 'h204, 0, 0, 0, NOP);
        add(1, 0, 0,  0, 0, 0,     1, 32'hFFFF_FFFC, 0, 0, 0, NOP);
        add(0, 1, I5, 0, 0, 0,     0, 32'hFFFF_FFFC, 0, 0, 0, NOP);
        add(0, 0, 0,  0, 0, 0,     1, 0,   1, 32'hFFFF_FFFC, 0, I5);
        add(1, 0, 0,  0, 1, R3,    1, 0,   0, 0, 0, NOP);
        add(0, 0, 0,  0, 0, 0,     0, 'h300, 0, 0, 0, NOP);
        add(0, 1, JK, 0, 0, 0,     0, 'h300, 0, 0, 0, NOP);
        add(0, 0, 0,  0, 0, 0,     1, 'h300, 0, 0, 0, NOP);
        add(1, 0, 0,  1, 0, 0,     1, 'h300, 0, 0, 0, NOP);
        add(0, 1, I6, 1, 0, 0,     0, 'h300, 0, 0, 0, NOP);
        add(0, 0, 0,  1, 0, 0,     1, 'h304, 1, 'h300, 'h304, I6);
        add(0, 0, 0,  0, 0, 0,     1, 'h304, 1, 'h300, 'h304, I6);
        add(0, 0, 0,  0, 0, 0,     1, 'h304, 0, 0, 0, NOP);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'd1);
        chk("rst_addr", req_addr, 32'h0);
        chk("rst_valid", 32'(v), 32'd0);
        chk("rst_pc", ipc, 32'h0);
        chk("rst_pc4", ipc4, 32'h0);
        chk("rst_instr", ins, NOP);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd,
                  tbl[i].st, tbl[i].rf, tbl[i].rpc);
            #1;
            chk($sformatf("row%0d_req", i), 32'(req_valid),
                32'(tbl[i].erq));
            chk($sformatf("row%0d_addr", i), req_addr, tbl[i].eaddr);
            chk($sformatf("row%0d_valid", i), 32'(v), 32'(tbl[i].ev));
            chk($sformatf("row%0d_instr", i), ins, tbl[i].eins);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_pc", i), ipc, tbl[i].epc);
                chk($sformatf("row%0d_pc4", i), ipc4, tbl[i].epc4);
            end
            @(negedge clk);
        end

        // reset mid-fetch with a live IF/ID entry
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, I1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_valid", 32'(v), 32'd1);
        chk("pre_rst_pc", ipc, 32'h304);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(v), 32'd0);
        chk("async_rst_instr", ins, NOP);
        chk("async_rst_addr", req_addr, 32'h0);
        chk("async_rst_req", 32'(req_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, JK, 0, 0, 0);
        #1;
        chk("stray_rsp_req", 32'(req_valid), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("stray_rsp_valid", 32'(v), 32'd0);
        chk("stray_rsp_instr", ins, NOP);
        chk("stray_rsp_req2", 32'(req_valid), 32'd1);
        chk("stray_rsp_addr", req_addr, 32'h0);

`ifdef IF_MISALIGN_CHECK_EN
        chk("mis_clear", 32'(misalign), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h0000_0102);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("mis_set", 32'(misalign), 32'd1);
        chk("mis_pc", req_addr, 32'h0000_0102);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mis_noreq%0d", k), 32'(req_valid), 32'd0);
            chk($sformatf("mis_sticky%0d", k), 32'(misalign), 32'd1);
            @(negedge clk);
            #1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
